// File: rtl/mem_monitor_pkg.sv
// Shared definitions for the Simplez memory monitor: operation codes,
// controller states and the default geometry of the 512x12 main memory.
package mem_monitor_pkg;

  localparam int AW_DEF = 9;   // 512-word address space
  localparam int DW_DEF = 12;  // Simplez word width
  localparam int LW_DEF = 9;   // block length field (count minus one)

  typedef enum logic [1:0] {
    OP_READ     = 2'b00,
    OP_WRITE    = 2'b01,
    OP_BLK_READ = 2'b10,
    OP_FILL     = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_RSP  = 2'b10,
    ST_WR   = 2'b11
  } state_t;

  // Block operations (BLK_READ, FILL) use the length field; singles do not.
  function automatic logic op_is_block(input op_t op);
    return op[1];
  endfunction

  // WRITE and FILL drive the memory write strobe; READ and BLK_READ do not.
  function automatic logic op_is_write(input op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/mem_monitor.sv
// Bus initiator for the Simplez main memory. Takes host commands (single
// read/write, block read, block fill), drives the memory port with
// registered signals and returns read words over a valid/ready stream.
// The memory responds on the negedge, so a read address driven at one
// posedge yields data that is captured at the next posedge.
module mem_monitor
  import mem_monitor_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  // host command channel
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  input  logic [LW-1:0] cmd_len,
  // read response channel
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          rsp_last,
  output logic          done,
  // memory port
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state_reg;
  logic [LW-1:0] cnt_reg;     // words remaining after the current one
  op_t           op_in;

  assign op_in     = op_t'(cmd_op);
  assign cmd_ready = (state_reg == ST_IDLE);

  // Single controller FSM; every output it drives is registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            mem_addr <= cmd_addr;
            cnt_reg  <= op_is_block(op_in) ? cmd_len : '0;
            if (op_is_write(op_in)) begin
              mem_wdata <= cmd_data;
              mem_wr    <= 1'b1;
              state_reg <= ST_WR;
            end else begin
              state_reg <= ST_RD;
            end
          end
        end

        // Memory has presented the word for mem_addr at the last negedge.
        ST_RD: begin
          rsp_data  <= mem_rdata;
          rsp_addr  <= mem_addr;
          rsp_valid <= 1'b1;
          rsp_last  <= (cnt_reg == '0);
          state_reg <= ST_RSP;
        end

        // Hold the response until the host takes it, then advance.
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (cnt_reg == '0) begin
              done      <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              cnt_reg   <= cnt_reg - LW'(1);
              mem_addr  <= mem_addr + AW'(1);
              state_reg <= ST_RD;
            end
          end
        end

        // One write per cycle; the strobe drops with the last word so a
        // block of N words keeps mem_wr high for exactly N cycles.
        ST_WR: begin
          if (cnt_reg == '0) begin
            mem_wr    <= 1'b0;
            done      <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg  <= cnt_reg - LW'(1);
            mem_addr <= mem_addr + AW'(1);
          end
        end

        default: begin
          mem_wr    <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_monitor.sv
// Directed bench for mem_monitor with a 512x12 negedge memory responder.
module tb_mem_monitor;
  import mem_monitor_pkg::*;

  localparam int AW = 9;
  localparam int DW = 12;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_last;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem [0:511];

  int errors = 0;
  int checks = 0;

  // write / accept monitor
  int            wr_cnt = 0;
  int            wr_runs = 0;
  int            bad_wr = 0;
  int            acc_cnt = 0;
  logic [AW-1:0] wr_log [0:63];
  logic          prev_wr = 1'b0;

  // captured responses
  logic [DW-1:0] got_d [0:7];
  logic [AW-1:0] got_a [0:7];
  logic          got_l [0:7];

  always #5 clk = ~clk;

  mem_monitor #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last), .done(done),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // negedge memory responder
  always @(negedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // observe the memory port and the command handshake between edges
  always @(negedge clk) begin
    if (mem_wr) begin
      if (wr_cnt < 64) wr_log[wr_cnt] = mem_addr;
      wr_cnt = wr_cnt + 1;
      if (!prev_wr) wr_runs = wr_runs + 1;
      if (cmd_ready) bad_wr = bad_wr + 1;
    end
    prev_wr = mem_wr;
    if (cmd_valid && cmd_ready) acc_cnt = acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a command and return just after the edge that accepts it
  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [LW-1:0] len,
                          input bit keep_valid);
    int n = 0;
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_len = len; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("accept_timeout", 32'(cmd_ready), 32'd1);
    tick();
    if (!keep_valid) cmd_valid = 1'b0;
    $display("cmd op=%0d addr=%0o data=%0o len=%0d accepted at %0t", op, a, d, len, $time);
  endtask

  // drain n responses; optionally toggle rsp_ready every cycle
  task automatic collect(input int n, input bit toggle);
    int   k = 0;
    int   cyc = 0;
    bit   rdy = 1'b1;
    bit   stall_prev = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic [AW-1:0] prev_a = '0;
    logic          prev_l = 1'b0;
    while (k < n && cyc < 200) begin
      if (stall_prev) begin
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_data", 32'(rsp_data), 32'(prev_d));
        check("hold_addr", 32'(rsp_addr), 32'(prev_a));
        check("hold_last", 32'(rsp_last), 32'(prev_l));
      end
      rsp_ready = rdy;
      if (rsp_valid && rdy) begin
        got_d[k] = rsp_data; got_a[k] = rsp_addr; got_l[k] = rsp_last;
        $display("rsp word %0d addr=%0o data=%0o last=%0b", k, rsp_addr, rsp_data, rsp_last);
        k++;
      end
      stall_prev = rsp_valid && !rdy;
      prev_d = rsp_data; prev_a = rsp_addr; prev_l = rsp_last;
      if (toggle) rdy = !rdy;
      tick();
      cyc++;
    end
    rsp_ready = 1'b0;
    if (k < n) check("rsp_timeout", 32'(k), 32'(n));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 600) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, runs0, acc0;
    logic [DW-1:0] blk_exp [0:3];
    logic [AW-1:0] fill_a  [0:3];

    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[0] = 12'o1006; mem[1] = 12'o1234;
    mem[4] = 12'o0004; mem[5] = 12'o0005; mem[6] = 12'o0002; mem[7] = 12'o0001;
    mem[510] = 12'o0510; mem[511] = 12'o0511;

    // ---------------- reset values ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_addr", 32'(rsp_addr), 32'd0);
    check("rst_rsp_last", 32'(rsp_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rstn = 1'b1;
    tick();

    // ---------------- single READ of address 0 ----------------
    base = wr_cnt;
    send_cmd(OP_READ, 9'd0, 12'd0, 9'd0, 1'b0);
    collect(1, 1'b0);
    check("rd0_data", 32'(got_d[0]), 32'o1006);
    check("rd0_addr", 32'(got_a[0]), 32'd0);
    check("rd0_last", 32'(got_l[0]), 32'd1);
    check("rd0_done", 32'(done), 32'd1);
    check("rd0_idle", 32'(cmd_ready), 32'd1);
    tick();
    check("rd0_done_pulse", 32'(done), 32'd0);
    check("rd0_no_write", 32'(wr_cnt - base), 32'd0);

    // ---------------- WRITE then READ 0o100 ----------------
    base = wr_cnt;
    send_cmd(OP_WRITE, 9'o100, 12'o0011, 9'd0, 1'b0);
    wait_done();
    tick();
    check("wr_count", 32'(wr_cnt - base), 32'd1);
    check("wr_addr", 32'(wr_log[base]), 32'o100);
    check("wr_mem", 32'(mem[9'o100]), 32'o0011);
    check("wr_no_rsp", 32'(rsp_valid), 32'd0);
    send_cmd(OP_READ, 9'o100, 12'd0, 9'd0, 1'b0);
    collect(1, 1'b0);
    check("rd100_data", 32'(got_d[0]), 32'o0011);
    check("rd100_addr", 32'(got_a[0]), 32'o100);
    tick();

    // ---------------- BLK_READ 4..7 with a stalling host ----------------
    blk_exp[0] = 12'o0004; blk_exp[1] = 12'o0005;
    blk_exp[2] = 12'o0002; blk_exp[3] = 12'o0001;
    send_cmd(OP_BLK_READ, 9'd4, 12'd0, 9'd3, 1'b0);
    collect(4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("blk_data%0d", i), 32'(got_d[i]), 32'(blk_exp[i]));
      check($sformatf("blk_addr%0d", i), 32'(got_a[i]), 32'(4 + i));
      check($sformatf("blk_last%0d", i), 32'(got_l[i]), (i == 3) ? 32'd1 : 32'd0);
    end
    check("blk_done", 32'(done), 32'd1);
    tick();

    // ---------------- FILL across the wrap, then read it back ----------------
    fill_a[0] = 9'd510; fill_a[1] = 9'd511; fill_a[2] = 9'd0; fill_a[3] = 9'd1;
    base = wr_cnt; runs0 = wr_runs;
    send_cmd(OP_FILL, 9'd510, 12'o7777, 9'd3, 1'b0);
    wait_done();
    tick();
    check("fill_count", 32'(wr_cnt - base), 32'd4);
    check("fill_runs", 32'(wr_runs - runs0), 32'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("fill_addr%0d", i), 32'(wr_log[base + i]), 32'(fill_a[i]));
    check("fill_mem2_untouched", 32'(mem[2]), 32'd0);
    send_cmd(OP_BLK_READ, 9'd510, 12'd0, 9'd3, 1'b0);
    collect(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_data%0d", i), 32'(got_d[i]), 32'o7777);
      check($sformatf("wrap_addr%0d", i), 32'(got_a[i]), 32'(fill_a[i]));
    end
    check("wrap_last", 32'(got_l[3]), 32'd1);
    tick();

    // ---------------- reset in the middle of a FILL ----------------
    for (int i = 100; i < 104; i++) mem[i] = 12'o0101;
    base = wr_cnt;
    send_cmd(OP_FILL, 9'd100, 12'o5555, 9'd3, 1'b0);
    tick();
    rstn = 1'b0;
    tick();
    check("abort_mem_wr", 32'(mem_wr), 32'd0);
    tick();
    check("abort_write_count", 32'(wr_cnt - base), 32'd2);
    check("abort_mem100", 32'(mem[100]), 32'o5555);
    check("abort_mem101", 32'(mem[101]), 32'o5555);
    check("abort_mem102", 32'(mem[102]), 32'o0101);
    check("abort_mem103", 32'(mem[103]), 32'o0101);
    rstn = 1'b1;
    tick();
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);

    // ---------------- cmd_valid held while busy ----------------
    acc0 = acc_cnt;
    send_cmd(OP_READ, 9'd4, 12'd0, 9'd0, 1'b1);
    cmd_addr = 9'd5;                // second command waits on the bus
    collect(1, 1'b0);
    check("b2b_first_data", 32'(got_d[0]), 32'o0004);
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_single_accept", 32'(acc_cnt - acc0), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("b2b_accepted_after_done", 32'(cmd_ready), 32'd0);
    check("b2b_accept_count", 32'(acc_cnt - acc0), 32'd2);
    collect(1, 1'b0);
    check("b2b_second_data", 32'(got_d[0]), 32'o0005);
    check("b2b_second_addr", 32'(got_a[0]), 32'd5);
    tick();

    check("wr_only_in_wr", 32'(bad_wr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
